taylor_series_pipe: RTL and testbench
=====================================

Name: taylor_series_pipe

Overview:
- Parametrised, handshaked pipeline that evaluates y = bias + sum_{k=1..n} c_k * x^k in fixed point; one series term per stage per pass.
- Items needing more terms than STAGES recirculate from the last stage back to stage 0.
- Two coefficient tables, selected per item:
  - ln(1+x): c_k = (-1)^(k+1)/k
  - exp(x)-1: c_k = 1/k!
- Sits between the input sequencer and the result collector; replaces the fixed 4-stage, 8-term evaluator.

Parameters:
XW, 16, width of x and x^k; unsigned Q0.XW fraction
ACC_W, 32, signed accumulator/coefficient width, XW fraction bits
STAGES, 4, pipeline stages (>=1)
MAX_TERMS, 8, largest legal term count
TAG_W, 4, item tag width
NW, $clog2(MAX_TERMS+1), term-count width (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  input item offered
in_ready  out  1  input accepted when in_valid && in_ready
in_x  in  XW  x, unsigned Q0.XW
in_n  in  NW  number of terms
in_func  in  1  0 = ln(1+x) table, 1 = exp(x)-1 table
in_bias  in  ACC_W  initial accumulator value
in_tag  in  TAG_W  returned unchanged with the result
out_valid  out  1  result present
out_ready  in  1  result consumed when out_valid && out_ready
out_y  out  ACC_W  result, signed Q(ACC_W-XW).XW
out_tag  out  TAG_W  tag of the result
out_ov  out  1  sticky accumulator overflow for this item
out_err  out  1  in_n > MAX_TERMS; n was clamped to MAX_TERMS

Behaviour:
- Each stage register holds: vld, x, pw, acc, k (terms done), n, func, tag, ov, err.
- Stage logic when k < n:
  - pw' = (k==0) ? x : (pw*x)>>XW
  - term = (pw' * c[func][k+1]) >>> XW (floor)
  - acc' = acc + term; ov' = ov | signed-add overflow; k' = k+1
- Stage logic when k >= n: pass through unchanged.
- Stage 0 entry values: acc = bias, k = 0, pw = 0, n = min(in_n, MAX_TERMS), err = (in_n > MAX_TERMS).
- n = 0 gives out_y = bias after a single pass.
- Last-stage item with k < n: recirculates into stage 0 on the next edge. Recirculation has priority over new input.
- Last-stage item with k >= n: drives out_*.
- stall = last_vld && done && !out_ready. During a stall every stage holds, including recirculation.
- in_ready = !stall && !(last_vld && !done). This is the only path from out_ready to in_ready.
- Latency without stalls: P = max(1, ceil(n/STAGES)) passes. out_valid rises P*STAGES-1 edges after the accepting edge.
- Throughput: one item per cycle for items with n <= STAGES.
- Ordering: results may complete out of order (a short item can overtake a recirculating one). out_tag identifies each result.
- out_* are driven directly from the last-stage register; stable while out_valid && !out_ready.
- Reset: asynchronous. All vld bits cleared, so out_valid = 0, out_y = 0, out_tag = 0, out_ov = 0, out_err = 0.
  - in_ready = 1 from the first cycle after rst deasserts.
  - Reset mid-operation discards all in-flight items, with no output.
- Simultaneous out_ready and done item: the item leaves and the pipeline advances on the same edge.

Optional Feature:
- Macro: TAYLOR_SATURATE_EN
- Defined: on a signed-add overflow, acc' clamps to the most positive or most negative ACC_W value in the direction of the overflow. Later terms continue from the clamped value. ov is still set.
- Undefined: acc wraps modulo 2^ACC_W; ov is set.

Decomposition:
- Package taylor_pkg holds:
  - default XW/ACC_W/STAGES/MAX_TERMS
  - FUNC_LN/FUNC_EXP encodings
  - the stage-record struct typedef
  - saturation limit constants
- One sub-module, taylor_coef_rom: combinational (func, k) -> c_k, parametrised on ACC_W, XW and MAX_TERMS. One instance per stage.
- Everything else (stage logic, recirculation, handshake) lives in taylor_series_pipe.

Test Plan:
- Defaults; x=0x8000, n=1, func=ln, bias=0 -> out_y=0x00008000; out_valid 3 edges after accept.
- x=0x8000, n=2, func=ln, bias=0 -> out_y=0x00006000, ov=0, err=0.
- x=0x8000, n=3, func=exp, bias=0 -> out_y=0x0000A555; c3=0x2AAA, so term3=0x0555.
- Tag 1 with n=8, next cycle tag 2 with n=1:
  - tag 2 emerges first, tag 1 after 7 edges.
  - in_ready is low on cycles where tag 1 recirculates.
- bias=0x7FFFFFFF, x=0x8000, n=1, ln -> out_ov=1; out_y=0x80007FFF, or 0x7FFFFFFF with TAYLOR_SATURATE_EN.
- n=9 -> err=1, result equals n=8.
- out_ready held low 5 cycles -> out_* stable, in_ready=0 during the stall.
- Reset asserted with 3 items in flight -> no outputs, in_ready=1 after release.

Source files
------------

// File: rtl/taylor_pkg.sv
// Shared constants and types for the Taylor-series evaluation pipeline.
package taylor_pkg;

    localparam int XW_DEF        = 16;
    localparam int ACC_W_DEF     = 32;
    localparam int STAGES_DEF    = 4;
    localparam int MAX_TERMS_DEF = 8;
    localparam int TAG_W_DEF     = 4;
    localparam int NW_DEF        = $clog2(MAX_TERMS_DEF + 1);

    localparam logic FUNC_LN  = 1'b0;
    localparam logic FUNC_EXP = 1'b1;

    // Stage record at the default geometry; the pipe re-declares it at its own widths.
    typedef struct packed {
        logic                        vld;
        logic [XW_DEF-1:0]           x;
        logic [XW_DEF-1:0]           pw;
        logic signed [ACC_W_DEF-1:0] acc;
        logic [NW_DEF-1:0]           k;
        logic [NW_DEF-1:0]           n;
        logic                        func;
        logic [TAG_W_DEF-1:0]        tag;
        logic                        ov;
        logic                        err;
    } stage_t;

    localparam logic signed [ACC_W_DEF-1:0] ACC_SAT_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic signed [ACC_W_DEF-1:0] ACC_SAT_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

endpackage

// File: rtl/taylor_series_pipe_if.sv
// Item-in / result-out handshake bundle of the Taylor-series pipeline.
interface taylor_series_pipe_if
    import taylor_pkg::*;
#(
    parameter int XW        = XW_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int TAG_W     = TAG_W_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int NW        = $clog2(MAX_TERMS + 1)
);
    logic                    in_valid;
    logic                    in_ready;
    logic [XW-1:0]           in_x;
    logic [NW-1:0]           in_n;
    logic                    in_func;
    logic signed [ACC_W-1:0] in_bias;
    logic [TAG_W-1:0]        in_tag;

    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_y;
    logic [TAG_W-1:0]        out_tag;
    logic                    out_ov;
    logic                    out_err;

    modport master (
        output in_valid, in_x, in_n, in_func, in_bias, in_tag, out_ready,
        input  in_ready, out_valid, out_y, out_tag, out_ov, out_err
    );

    modport slave (
        input  in_valid, in_x, in_n, in_func, in_bias, in_tag, out_ready,
        output in_ready, out_valid, out_y, out_tag, out_ov, out_err
    );
endinterface

// File: rtl/taylor_coef_rom.sv
// Constant coefficient tables: ln(1+x) -> (-1)^(k+1)/k, exp(x)-1 -> 1/k!, in Q.XW.
module taylor_coef_rom
    import taylor_pkg::*;
#(
    parameter int ACC_W     = ACC_W_DEF,
    parameter int XW        = XW_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int NW        = $clog2(MAX_TERMS + 1)
) (
    input  logic                    func,
    input  logic [NW-1:0]           k,
    output logic signed [ACC_W-1:0] coef
);

    // Magnitudes are floored before the sign is applied.
    function automatic logic signed [ACC_W-1:0] ln_coef(input int idx);
        logic signed [ACC_W-1:0] mag;
        if (idx == 0) return '0;
        mag = ACC_W'((64'd1 << XW) / 64'(idx));
        return (idx % 2 == 1) ? mag : -mag;
    endfunction

    function automatic logic signed [ACC_W-1:0] exp_coef(input int idx);
        logic [63:0] fact;
        if (idx == 0) return '0;
        fact = 64'd1;
        for (int i = 2; i <= idx; i++) fact = fact * 64'(i);
        return ACC_W'((64'd1 << XW) / fact);
    endfunction

    logic signed [ACC_W-1:0] ln_tab  [MAX_TERMS+1];
    logic signed [ACC_W-1:0] exp_tab [MAX_TERMS+1];

    for (genvar i = 0; i <= MAX_TERMS; i++) begin : g_tab
        localparam logic signed [ACC_W-1:0] LN_C  = ln_coef(i);
        localparam logic signed [ACC_W-1:0] EXP_C = exp_coef(i);
        assign ln_tab[i]  = LN_C;
        assign exp_tab[i] = EXP_C;
    end

    always_comb begin
        coef = '0;
        if (k != '0 && k <= NW'(MAX_TERMS)) begin
            coef = (func == FUNC_EXP) ? exp_tab[k] : ln_tab[k];
        end
    end

endmodule

// File: rtl/taylor_series_pipe.sv
// Recirculating pipeline computing y = bias + sum c_k x^k, one term per stage per pass.
// Build option: define TAYLOR_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module taylor_series_pipe
    import taylor_pkg::*;
#(
    parameter int XW        = XW_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int STAGES    = STAGES_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int TAG_W     = TAG_W_DEF,
    parameter int NW        = $clog2(MAX_TERMS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    taylor_series_pipe_if.slave  bus
);

    localparam int SQ_W   = 2 * XW;
    localparam int PROD_W = XW + ACC_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef struct packed {
        logic                    vld;
        logic [XW-1:0]           x;
        logic [XW-1:0]           pw;
        logic signed [ACC_W-1:0] acc;
        logic [NW-1:0]           k;
        logic [NW-1:0]           n;
        logic                    func;
        logic [TAG_W-1:0]        tag;
        logic                    ov;
        logic                    err;
    } rec_t;

    function automatic logic [XW-1:0] next_pw(input rec_t r);
        logic [SQ_W-1:0] prod;
        if (r.k == '0) return r.x;
        prod = SQ_W'(r.pw) * SQ_W'(r.x);
        return XW'(prod >> XW);
    endfunction

    // Arithmetic shift gives floor rounding for negative coefficients.
    function automatic logic signed [ACC_W-1:0] scale_term(input logic [XW-1:0] pw,
                                                           input logic signed [ACC_W-1:0] c);
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'($signed({1'b0, pw})) * PROD_W'(c);
        return ACC_W'(prod >>> XW);
    endfunction

    // Returns {overflow, sum}.
    function automatic logic [ACC_W:0] add_ov(input logic signed [ACC_W-1:0] acc,
                                              input logic signed [ACC_W-1:0] term);
        logic signed [ACC_W-1:0] sum;
        logic                    ov;
        sum = acc + term;
        ov  = (acc[ACC_W-1] == term[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
`ifdef TAYLOR_SATURATE_EN
        if (ov) sum = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
`endif
        return {ov, sum};
    endfunction

    function automatic rec_t stage_step(input rec_t r, input logic signed [ACC_W-1:0] c);
        rec_t          o;
        logic [XW-1:0] pw;
        logic [ACC_W:0] res;
        o = r;
        if (r.vld && r.k < r.n) begin
            pw    = next_pw(r);
            res   = add_ov(r.acc, scale_term(pw, c));
            o.pw  = pw;
            o.acc = res[ACC_W-1:0];
            o.ov  = r.ov | res[ACC_W];
            o.k   = r.k + NW'(1);
        end
        return o;
    endfunction

    rec_t                    stage_q  [STAGES];
    rec_t                    stage_d  [STAGES];
    rec_t                    stage_in [STAGES];
    logic [NW-1:0]           coef_k   [STAGES];
    logic signed [ACC_W-1:0] coef     [STAGES];
    rec_t                    entry;
    rec_t                    last;
    logic                    last_done;
    logic                    recirc;
    logic                    stall;
    logic                    in_ready;

    assign last      = stage_q[STAGES-1];
    assign last_done = last.k >= last.n;
    assign recirc    = last.vld && !last_done;
    assign stall     = last.vld && last_done && !bus.out_ready;
    assign in_ready  = !stall && !recirc;

    always_comb begin
        entry      = '0;
        entry.vld  = bus.in_valid && in_ready;
        entry.x    = bus.in_x;
        entry.acc  = bus.in_bias;
        entry.func = bus.in_func;
        entry.tag  = bus.in_tag;
        entry.err  = bus.in_n > NW'(MAX_TERMS);
        entry.n    = entry.err ? NW'(MAX_TERMS) : bus.in_n;
    end

    // Recirculating items take stage 0 ahead of new input.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            stage_in[i] = '0;
            coef_k[i]   = '0;
        end
        stage_in[0] = recirc ? last : entry;
        for (int i = 1; i < STAGES; i++) stage_in[i] = stage_q[i-1];
        for (int i = 0; i < STAGES; i++) coef_k[i] = stage_in[i].k + NW'(1);
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_rom
        taylor_coef_rom #(
            .ACC_W     (ACC_W),
            .XW        (XW),
            .MAX_TERMS (MAX_TERMS),
            .NW        (NW)
        ) u_rom (
            .func (stage_in[g].func),
            .k    (coef_k[g]),
            .coef (coef[g])
        );
    end

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            stage_d[i] = stall ? stage_q[i] : stage_step(stage_in[i], coef[i]);
        end
    end

    // Stage register boundary; output state is cleared along with valids.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= stage_d[i];
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = last.vld && last_done;
    assign bus.out_y     = last.acc;
    assign bus.out_tag   = last.tag;
    assign bus.out_ov    = last.ov;
    assign bus.out_err   = last.err;

endmodule

// File: tb/tb_taylor_series_pipe.sv
// Directed bench for taylor_series_pipe with a tag-matched result scoreboard.
module tb_taylor_series_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_out = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    taylor_series_pipe_if bus ();

    taylor_series_pipe dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] y;
        logic        ov;
        logic        err;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] out_order[$];

    int LN_C  [9] = '{0, 65536, -32768, 21845, -16384, 13107, -10922, 9362, -8192};
    int EXP_C [9] = '{0, 65536, 32768, 10922, 2730, 546, 91, 13, 1};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [15:0] x, input int n, input bit f,
                                  input logic signed [31:0] bias,
                                  output logic [31:0] y, output bit ov);
        longint pw, acc, term, sum, c;
        int     nn;
        nn  = (n > 8) ? 8 : n;
        acc = longint'(bias);
        pw  = 0;
        ov  = 0;
        for (int k = 1; k <= nn; k++) begin
            pw   = (k == 1) ? longint'(x) : ((pw * longint'(x)) >> 16);
            c    = f ? longint'(EXP_C[k]) : longint'(LN_C[k]);
            term = (pw * c) >>> 16;
            sum  = acc + term;
            if (sum > 64'sd2147483647 || sum < -64'sd2147483648) begin
                ov = 1;
`ifdef TAYLOR_SATURATE_EN
                sum = (sum > 0) ? 64'sd2147483647 : -64'sd2147483648;
`else
                sum = longint'(int'(sum));
`endif
            end
            acc = sum;
        end
        y = acc[31:0];
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            int idx;
            idx = -1;
            n_out++;
            out_order.push_back(bus.out_tag);
            for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].tag == bus.out_tag) idx = i;
            if (idx < 0) begin
                chk("sb_unexpected_tag", 64'(bus.out_tag), 64'hFFFF);
            end else begin
                chk("sb_y",   64'($unsigned(bus.out_y)), 64'(exp_q[idx].y));
                chk("sb_ov",  64'(bus.out_ov),  64'(exp_q[idx].ov));
                chk("sb_err", 64'(bus.out_err), 64'(exp_q[idx].err));
                exp_q.delete(idx);
            end
        end
    end

    task automatic send(input logic [15:0] x, input logic [3:0] n, input bit f,
                        input logic [31:0] bias, input logic [3:0] tag,
                        input logic [31:0] ey, input bit eov, input bit eerr,
                        output int acc_cyc);
        exp_t e;
        bit   ok;
        e.tag = tag; e.y = ey; e.ov = eov; e.err = eerr;
        exp_q.push_back(e);
        bus.in_valid = 1'b1; bus.in_x = x; bus.in_n = n; bus.in_func = f;
        bus.in_bias = bias; bus.in_tag = tag;
        ok = 0;
        acc_cyc = -1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (ok) acc_cyc = cyc;
        else chk("accept_timeout", 64'(tag), 64'hFFFF);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_model(input logic [15:0] x, input logic [3:0] n, input bit f,
                              input logic [31:0] bias, input logic [3:0] tag, output int acc_cyc);
        logic [31:0] y;
        bit          ov;
        model(x, int'(n), f, bias, y, ov);
        send(x, n, f, bias, tag, y, ov, n > 4'd8, acc_cyc);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 100) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int a, b, c, n0;
        logic [31:0] y_stall, y_sat;
        bit ov_s;

        bus.in_valid = 0; bus.in_x = '0; bus.in_n = '0; bus.in_func = 0;
        bus.in_bias = '0; bus.in_tag = '0; bus.out_ready = 1'b1;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_y",     64'($unsigned(bus.out_y)), 64'd0);
        chk("rst_out_tag",   64'(bus.out_tag), 64'd0);
        chk("rst_out_ov",    64'(bus.out_ov), 64'd0);
        chk("rst_out_err",   64'(bus.out_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // single term, latency
        send(16'h8000, 4'd1, 1'b0, 32'd0, 4'd3, 32'h00008000, 1'b0, 1'b0, a);
        wait_cyc(a + 2);
        chk("lat_early", 64'(bus.out_valid), 64'd0);
        wait_cyc(a + 3);
        chk("lat_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_tag",   64'(bus.out_tag), 64'd3);
        drain();

        send(16'h8000, 4'd2, 1'b0, 32'd0, 4'd4, 32'h00006000, 1'b0, 1'b0, a);
        send(16'h8000, 4'd3, 1'b1, 32'd0, 4'd5, 32'h0000A555, 1'b0, 1'b0, a);
        drain();

        // overtaking
        out_order.delete();
        send_model(16'h9000, 4'd8, 1'b0, 32'd100, 4'd1, a);
        send_model(16'h4000, 4'd1, 1'b1, 32'd0, 4'd2, b);
        chk("ovt_accept_next", 64'(b - a), 64'd1);
        wait_cyc(a + 2);
        chk("ovt_ready_before", 64'(bus.in_ready), 64'd1);
        wait_cyc(a + 3);
        chk("ovt_ready_recirc", 64'(bus.in_ready), 64'd0);
        wait_cyc(a + 4);
        chk("ovt_first_valid", 64'(bus.out_valid), 64'd1);
        chk("ovt_first_tag",   64'(bus.out_tag), 64'd2);
        wait_cyc(a + 6);
        chk("ovt_t1_not_yet", 64'(bus.out_valid), 64'd0);
        wait_cyc(a + 7);
        chk("ovt_t1_valid", 64'(bus.out_valid), 64'd1);
        chk("ovt_t1_tag",   64'(bus.out_tag), 64'd1);
        drain();
        chk("ovt_order_len", 64'(out_order.size()), 64'd2);
        if (out_order.size() == 2) begin
            chk("ovt_order0", 64'(out_order[0]), 64'd2);
            chk("ovt_order1", 64'(out_order[1]), 64'd1);
        end

        // overflow
`ifdef TAYLOR_SATURATE_EN
        y_sat = 32'h7FFFFFFF;
`else
        y_sat = 32'h80007FFF;
`endif
        send(16'h8000, 4'd1, 1'b0, 32'h7FFFFFFF, 4'd6, y_sat, 1'b1, 1'b0, a);
        send_model(16'hF000, 4'd3, 1'b1, 32'h7FFFF000, 4'd7, a);
        drain();

        // term-count clamp
        send_model(16'hC000, 4'd9, 1'b0, 32'd0, 4'd8, a);
        send_model(16'hC000, 4'd8, 1'b0, 32'd0, 4'd9, a);
        send_model(16'hC000, 4'd15, 1'b1, 32'hFFFF0000, 4'd10, a);
        drain();

        // stall
        bus.out_ready = 1'b0;
        model(16'h6000, 2, 1'b1, 32'd7, y_stall, ov_s);
        send(16'h6000, 4'd2, 1'b1, 32'd7, 4'd11, y_stall, ov_s, 1'b0, a);
        wait_cyc(a + 3);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_y",     64'($unsigned(bus.out_y)), 64'(y_stall));
            chk("stall_tag",   64'(bus.out_tag), 64'd11);
            chk("stall_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        drain();

        // back-to-back throughput
        send_model(16'(32'($urandom_range(0, 65535))), 4'd4, 1'b0, 32'($urandom_range(0, 4095)), 4'd12, a);
        send_model(16'(32'($urandom_range(0, 65535))), 4'd3, 1'b1, 32'd0, 4'd13, b);
        send_model(16'(32'($urandom_range(0, 65535))), 4'd0, 1'b0, 32'h12345678, 4'd14, c);
        chk("tput_ab", 64'(b - a), 64'd1);
        chk("tput_bc", 64'(c - b), 64'd1);
        drain();

        // reset with items in flight
        send_model(16'h7000, 4'd8, 1'b0, 32'd0, 4'd1, a);
        send_model(16'h7100, 4'd8, 1'b1, 32'd0, 4'd2, a);
        send_model(16'h7200, 4'd8, 1'b0, 32'd0, 4'd3, a);
        n0 = n_out;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_out", 64'(n_out), 64'(n0));
        chk("midrst_idle",   64'(bus.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
